mem_responder: RTL and testbench
================================

# mem_responder

Word-addressed unified instruction/data memory that serves the multicycle processor datapath's memory port: it accepts address, write data and write enable, and returns read data after a fixed, programmable number of wait states with a one-cycle ready pulse. It sits between the controller/datapath pair and the memory array. It replaces the zero-latency behavioural memory so the controller FSM can be exercised against real wait states and error responses.

## Interface
- DEPTH, 64: number of 32-bit words in the array.
- WAIT_CYCLES, 2: wait-state cycles inserted between request acceptance and response; 0 is legal.
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- MemReq  input  1  request strobe; sampled only in IDLE.
- MemWrite  input  1  1 = write, 0 = read; captured with the request.
- Adr  input  32  byte address; captured with the request.
- WriteData  input  32  store data; captured with the request.
- ReadData  output  32  registered read data; valid while MemReady=1, held afterwards.
- MemReady  output  1  one-cycle response pulse.
- MemErr  output  1  error flag; valid only while MemReady=1.

## Operation
- States: IDLE, BUSY, RESP. Reset: state=IDLE, ReadData=0, MemReady=0, MemErr=0, wait counter=0, captured registers=0. Array contents are not cleared by reset.
- IDLE: MemReq=1 captures Adr, WriteData and MemWrite, then moves to BUSY with counter=WAIT_CYCLES-1, or directly to RESP if WAIT_CYCLES=0. MemReq=0 stays in IDLE.
- BUSY: decrement the counter each cycle. When the counter equals 0, move to RESP. MemReq and input changes are ignored; only the captured values are used.
- On the edge entering RESP:
  - Word index = captured Adr[31:2].
  - Error condition: index >= DEPTH, or a misaligned address (only when the macro is defined; see Configuration).
  - No error and write: array[index] <= WriteData. ReadData keeps its previous value.
  - No error and read: ReadData <= array[index].
  - Error: no array update, ReadData <= 0, MemErr <= 1.
- RESP: MemReady=1 for exactly one cycle, then unconditionally IDLE. A MemReq during RESP is not accepted. MemErr clears on leaving RESP.
- Reset in BUSY or RESP: abort to IDLE. A pending write is discarded and the array is left unchanged.

## Timing
- Request sampled at edge E0 (IDLE, MemReq=1). MemReady is high during cycle 1+WAIT_CYCLES after E0:
  - WAIT_CYCLES=0: the cycle after E0.
  - WAIT_CYCLES=2: the third cycle after E0.
- A write is visible to a read issued any time after its MemReady cycle.
- Maximum throughput is one transaction per WAIT_CYCLES+2 cycles. The earliest re-acceptance is the cycle after RESP.
- ReadData changes only on the edge entering RESP of a successful read, on an error response (goes to 0), or on reset.

## Configuration
- MEM_ALIGN_CHECK_EN defined: a captured Adr[1:0] != 0 makes the transaction an error (MemErr=1, ReadData=0, write suppressed).
- MEM_ALIGN_CHECK_EN undefined: Adr[1:0] is ignored and the access goes to word Adr[31:2]. MemErr reports only out-of-range accesses.

## Test plan
- Reset, then read Adr=0x0 with WAIT_CYCLES=2 -> MemReady exactly 3 cycles after acceptance, ReadData=array[0], MemErr=0.
- Write 0xDEADBEEF to Adr=0x10, then read Adr=0x10 -> ReadData=0xDEADBEEF. MemReady is high for exactly one cycle on each transaction.
- Read Adr=0x100 with DEPTH=64 (index 64) -> MemErr=1, ReadData=0. A write to the same address leaves array[63] unchanged.
- Write to Adr=0x6:
  - With MEM_ALIGN_CHECK_EN -> MemErr=1 and array[1] unchanged.
  - Without it -> array[1] is written and MemErr=0.
- Hold MemReq=1 continuously with WAIT_CYCLES=0 -> MemReady pulses every 2nd cycle. Changing Adr during BUSY or RESP does not affect the response.
- Assert reset in the BUSY cycle of a write of 0x12345678 to Adr=0x8 -> no MemReady, state IDLE, subsequent read of 0x8 returns the old contents.

Source files
------------

// File: rtl/mem_responder_if.sv
// Memory-port bundle between the processor datapath (master) and mem_responder (slave).
interface mem_responder_if;
  logic        MemReq;
  logic        MemWrite;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        MemReady;
  logic        MemErr;

  modport master (
    output MemReq, MemWrite, Adr, WriteData,
    input  ReadData, MemReady, MemErr
  );

  modport slave (
    input  MemReq, MemWrite, Adr, WriteData,
    output ReadData, MemReady, MemErr
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed unified memory with WAIT_CYCLES wait states and a one-cycle ready pulse.
// Optional feature: define MEM_ALIGN_CHECK_EN to flag misaligned addresses as errors.
module mem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = 16;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          enter_resp;
  logic [31:0]   adr_sel;
  logic [31:0]   wdata_sel;
  logic          we_sel;
  logic [29:0]   word_idx;
  logic [AW-1:0] mem_idx;
  logic          acc_err;
  logic          mem_we;

  // With zero wait states RESP is entered on the accepting edge, so the live bus
  // values stand in for the not-yet-loaded capture registers.
  assign accept     = (state_q == IDLE) && bus.MemReq;
  assign enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                      ((state_q == BUSY) && (cnt_q == '0));
  assign adr_sel    = (state_q == IDLE) ? bus.Adr       : adr_q;
  assign wdata_sel  = (state_q == IDLE) ? bus.WriteData : wdata_q;
  assign we_sel     = (state_q == IDLE) ? bus.MemWrite  : we_q;
  assign word_idx   = adr_sel[31:2];
  assign mem_idx    = word_idx[AW-1:0];

`ifdef MEM_ALIGN_CHECK_EN
  assign acc_err = ({2'b00, word_idx} >= 32'(DEPTH)) || (adr_sel[1:0] != 2'b00);
`else
  logic unused_adr_lsbs;
  assign unused_adr_lsbs = ^adr_sel[1:0];
  assign acc_err         = ({2'b00, word_idx} >= 32'(DEPTH));
`endif

  // A reset on the RESP-entry edge aborts the transaction, pending write included.
  assign mem_we = enter_resp && !acc_err && we_sel && !reset;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the array has no reset; clearing a RAM would need a per-word sequencer
  // and the contents are deliberately preserved across reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= wdata_sel;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: every comb output is given a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.MemReq) state_d = (WAIT_CYCLES == 0) ? RESP : BUSY;
      BUSY:    if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture, wait counter and response datapath
  always_comb begin
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    if (accept) begin
      adr_d   = bus.Adr;
      wdata_d = bus.WriteData;
      we_d    = bus.MemWrite;
      cnt_d   = CW'(WAIT_CYCLES - 1);
    end

    if ((state_q == BUSY) && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end

    if (enter_resp) begin
      err_d = acc_err;
      if (acc_err) begin
        rdata_d = '0;
      end else if (!we_sel) begin
        rdata_d = mem[mem_idx];
      end
    end

    if (state_q == RESP) begin
      err_d = 1'b0;
    end
  end

  // Output logic
  always_comb begin
    bus.MemReady = (state_q == RESP);
    bus.ReadData = rdata_q;
    bus.MemErr   = err_q;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder: one instance with 2 wait states,
// one with 0 wait states for the back-to-back throughput stream.
module tb_mem_responder;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_responder_if bus0 ();
  mem_responder_if bus1 ();

  mem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  mem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // One transaction on dut0; inputs are scrambled while it is in flight.
  task automatic txn0(input string tag, input logic we, input logic [31:0] adr,
                      input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
    int lat;
    lat = 0;
    @(negedge clk);
    bus0.MemReq    = 1'b1;
    bus0.MemWrite  = we;
    bus0.Adr       = adr;
    bus0.WriteData = wdata;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      bus0.MemReq    = 1'b0;
      bus0.MemWrite  = ~we;
      bus0.Adr       = adr ^ 32'h0000_0004;
      bus0.WriteData = ~wdata;
      if (bus0.MemReady) begin
        lat = k;
        break;
      end
    end
    rdata = bus0.ReadData;
    err   = bus0.MemErr;
    check({tag, " latency"}, 32'(lat), 32'd3);
    @(negedge clk);
    check({tag, " ready width"}, 32'(bus0.MemReady), 32'd0);
    check({tag, " err cleared"}, 32'(bus0.MemErr), 32'd0);
    check({tag, " rdata held"}, bus0.ReadData, rdata);
    bus0.MemWrite = 1'b0;
  endtask

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        exp_rdy;
    logic        chk_data;
    logic [31:0] exp_data;
  } vec_t;

  // At each negedge: check outputs of the previous edge, then apply the new inputs.
  vec_t vecs [9] = '{
    '{1'b1, 1'b1, 32'h08, 32'h77,   1'b0, 1'b0, 32'h0},
    '{1'b1, 1'b1, 32'h08, 32'hBAD0, 1'b1, 1'b0, 32'h0},
    '{1'b1, 1'b1, 32'h04, 32'h11,   1'b0, 1'b0, 32'h0},
    '{1'b1, 1'b1, 32'h04, 32'hBAD1, 1'b1, 1'b0, 32'h0},
    '{1'b1, 1'b0, 32'h08, 32'h0,    1'b0, 1'b0, 32'h0},
    '{1'b1, 1'b1, 32'h08, 32'hBAD2, 1'b1, 1'b1, 32'h77},
    '{1'b1, 1'b0, 32'h04, 32'h0,    1'b0, 1'b0, 32'h0},
    '{1'b0, 1'b0, 32'h0,  32'h0,    1'b1, 1'b1, 32'h11},
    '{1'b0, 1'b0, 32'h0,  32'h0,    1'b0, 1'b0, 32'h0}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          rdy_cnt;

    reset = 1'b1;
    bus0.MemReq = 1'b0; bus0.MemWrite = 1'b0; bus0.Adr = '0; bus0.WriteData = '0;
    bus1.MemReq = 1'b0; bus1.MemWrite = 1'b0; bus1.Adr = '0; bus1.WriteData = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset rdata", bus0.ReadData, 32'h0);
    check("reset ready", 32'(bus0.MemReady), 32'd0);
    check("reset err", 32'(bus0.MemErr), 32'd0);
    check("reset rdata1", bus1.ReadData, 32'h0);

    txn0("wr0", 1'b1, 32'h00, 32'h0000_A000, rd, er);
    check("wr0 err", 32'(er), 32'd0);
    txn0("rd0", 1'b0, 32'h00, 32'h0, rd, er);
    check("rd0 data", rd, 32'h0000_A000);
    check("rd0 err", 32'(er), 32'd0);

    txn0("wr10", 1'b1, 32'h10, 32'hDEAD_BEEF, rd, er);
    check("wr10 keeps rdata", rd, 32'h0000_A000);
    txn0("rd10", 1'b0, 32'h10, 32'h0, rd, er);
    check("rd10 data", rd, 32'hDEAD_BEEF);

    txn0("wrfc", 1'b1, 32'hFC, 32'h6363_6363, rd, er);
    txn0("rdfc", 1'b0, 32'hFC, 32'h0, rd, er);
    check("rdfc data", rd, 32'h6363_6363);

    txn0("rd100", 1'b0, 32'h100, 32'h0, rd, er);
    check("rd100 err", 32'(er), 32'd1);
    check("rd100 data", rd, 32'h0);
    txn0("rdfc2", 1'b0, 32'hFC, 32'h0, rd, er);
    txn0("wr100", 1'b1, 32'h100, 32'h0000_0BAD, rd, er);
    check("wr100 err", 32'(er), 32'd1);
    check("wr100 data", rd, 32'h0);
    txn0("rdfc3", 1'b0, 32'hFC, 32'h0, rd, er);
    check("array63 intact", rd, 32'h6363_6363);

    txn0("wr4", 1'b1, 32'h04, 32'h0101_0101, rd, er);
    txn0("wr6", 1'b1, 32'h06, 32'h0606_0606, rd, er);
`ifdef MEM_ALIGN_CHECK_EN
    check("wr6 err", 32'(er), 32'd1);
`else
    check("wr6 err", 32'(er), 32'd0);
`endif
    txn0("rd4", 1'b0, 32'h04, 32'h0, rd, er);
`ifdef MEM_ALIGN_CHECK_EN
    check("rd4 data", rd, 32'h0101_0101);
`else
    check("rd4 data", rd, 32'h0606_0606);
`endif

    // Reset during BUSY of a write must discard it.
    txn0("wr8", 1'b1, 32'h08, 32'hCAFE_0008, rd, er);
    @(negedge clk);
    bus0.MemReq = 1'b1; bus0.MemWrite = 1'b1; bus0.Adr = 32'h08; bus0.WriteData = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    bus0.MemReq = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort rdata reset", bus0.ReadData, 32'h0);
    rdy_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus0.MemReady) rdy_cnt++;
      @(negedge clk);
    end
    check("abort no ready", 32'(rdy_cnt), 32'd0);
    txn0("rd8", 1'b0, 32'h08, 32'h0, rd, er);
    check("rd8 old data", rd, 32'hCAFE_0008);

    // Zero-wait-state stream with MemReq held high on dut1.
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      check($sformatf("stream%0d ready", c), 32'(bus1.MemReady), 32'(vecs[c].exp_rdy));
      if (vecs[c].chk_data) begin
        check($sformatf("stream%0d data", c), bus1.ReadData, vecs[c].exp_data);
        check($sformatf("stream%0d err", c), 32'(bus1.MemErr), 32'd0);
      end
      bus1.MemReq    = vecs[c].req;
      bus1.MemWrite  = vecs[c].we;
      bus1.Adr       = vecs[c].adr;
      bus1.WriteData = vecs[c].wd;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
